// File: rtl/cga_vram_arbiter.sv
// CGA video RAM arbiter: display fetches always own the RAM port; CPU (ISA) accesses run in sequencer-granted slots.
// Optional macro CGA_SNOW_EN: an 80-column ISA write replaces the next fetched character with the write data.
module cga_vram_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hres_mode,
  input  logic        vram_read,
  input  logic        vram_read_a0,
  input  logic        vram_read_char,
  input  logic        vram_read_att,
  input  logic        isa_op_enable,
  input  logic [12:0] disp_addr,
  input  logic        isa_req,
  input  logic        isa_we,
  input  logic [13:0] isa_addr,
  input  logic [7:0]  isa_din,
  output logic [7:0]  isa_dout,
  output logic        isa_ack,
  output logic [13:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  char_byte,
  output logic [7:0]  att_byte
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACC1,
    S_ACC2,
    S_ACC3,
    S_HOLD
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_latch;
  logic        r_we;
  logic [13:0] r_addr;
  logic [7:0]  r_din;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (isa_req) begin
          w_latch      = 1'b1;
          w_state_next = isa_op_enable ? S_ACC1 : S_WAIT;
        end
      end
      S_WAIT: begin
        if (isa_op_enable) begin
          w_state_next = S_ACC1;
        end
      end
      S_ACC1:  w_state_next = S_ACC2;
      S_ACC2:  w_state_next = S_ACC3;
      S_ACC3:  w_state_next = S_HOLD;
      // One request yields one access: wait for the CPU to drop its request.
      S_HOLD: begin
        if (!isa_req) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we   <= 1'b0;
      r_addr <= 14'h0000;
      r_din  <= 8'h00;
    end else if (w_latch) begin
      r_we   <= isa_we;
      r_addr <= isa_addr;
      r_din  <= isa_din;
    end
  end

  // ACC3 sees the data for the address held through ACC2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      isa_dout <= 8'h00;
    end else if ((r_state == S_ACC3) && !r_we) begin
      isa_dout <= ram_rdata;
    end
  end

  always_comb begin
    isa_ack   = (r_state == S_ACC3);
    ram_wdata = r_din;
    ram_addr  = 14'h0000;
    ram_we    = 1'b0;
    if (vram_read) begin
      ram_addr = {disp_addr, vram_read_a0};
    end else if ((r_state == S_ACC1) || (r_state == S_ACC2)) begin
      ram_addr = r_addr;
      ram_we   = (r_state == S_ACC1) && r_we;
    end
  end

`ifdef CGA_SNOW_EN
  logic       r_snow;
  logic [7:0] r_snow_data;
  logic       w_snow_set;

  assign w_snow_set = (r_state == S_ACC1) && r_we && hres_mode && !vram_read;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      char_byte   <= 8'h00;
      att_byte    <= 8'h00;
      r_snow      <= 1'b0;
      r_snow_data <= 8'h00;
    end else begin
      if (vram_read_char) begin
        char_byte <= r_snow ? r_snow_data : ram_rdata;
        r_snow    <= 1'b0;
      end else if (w_snow_set) begin
        r_snow      <= 1'b1;
        r_snow_data <= r_din;
      end
      if (vram_read_att) begin
        att_byte <= ram_rdata;
      end
    end
  end
`else
  logic w_unused_hres;
  assign w_unused_hres = hres_mode;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      char_byte <= 8'h00;
      att_byte  <= 8'h00;
    end else begin
      if (vram_read_char) begin
        char_byte <= ram_rdata;
      end
      if (vram_read_att) begin
        att_byte <= ram_rdata;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed bench for cga_vram_arbiter with a synchronous VRAM model and counters for write strobes and acks.
module tb_cga_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hres_mode;
  logic        vram_read;
  logic        vram_read_a0;
  logic        vram_read_char;
  logic        vram_read_att;
  logic        isa_op_enable;
  logic [12:0] disp_addr;
  logic        isa_req;
  logic        isa_we;
  logic [13:0] isa_addr;
  logic [7:0]  isa_din;
  logic [7:0]  isa_dout;
  logic        isa_ack;
  logic [13:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;
  logic [7:0]  char_byte;
  logic [7:0]  att_byte;

  logic [7:0]  mem [0:16383];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_we     = 0;
  int          n_ack    = 0;
  int          we0;
  int          ack0;
  logic [7:0]  snow_exp;

  always #5 clk = ~clk;

  cga_vram_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .hres_mode      (hres_mode),
    .vram_read      (vram_read),
    .vram_read_a0   (vram_read_a0),
    .vram_read_char (vram_read_char),
    .vram_read_att  (vram_read_att),
    .isa_op_enable  (isa_op_enable),
    .disp_addr      (disp_addr),
    .isa_req        (isa_req),
    .isa_we         (isa_we),
    .isa_addr       (isa_addr),
    .isa_din        (isa_din),
    .isa_dout       (isa_dout),
    .isa_ack        (isa_ack),
    .ram_addr       (ram_addr),
    .ram_we         (ram_we),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .char_byte      (char_byte),
    .att_byte       (att_byte)
  );

  // Synchronous VRAM: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (ram_we === 1'b1) n_we++;
    if (isa_ack === 1'b1) n_ack++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [12:0] d);
    disp_addr = d; vram_read = 1'b1; vram_read_a0 = 1'b0;
    tick();
    vram_read_a0 = 1'b1; vram_read_char = 1'b1;
    tick();
    vram_read = 1'b0; vram_read_a0 = 1'b0; vram_read_char = 1'b0; vram_read_att = 1'b1;
    tick();
    vram_read_att = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; hres_mode = 1'b0; vram_read = 1'b0; vram_read_a0 = 1'b0;
    vram_read_char = 1'b0; vram_read_att = 1'b0; isa_op_enable = 1'b0;
    disp_addr = 13'h0000; isa_req = 1'b0; isa_we = 1'b0; isa_addr = 14'h0000; isa_din = 8'h00;
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h0246] = 8'h41; mem[14'h0247] = 8'h1F;
    mem[14'h0400] = 8'h7A; mem[14'h0401] = 8'h07;
    mem[14'h1234] = 8'h5C;
    #2;
    chk("rst_ack", {15'd0, isa_ack}, 16'h0000);
    chk("rst_we", {15'd0, ram_we}, 16'h0000);
    chk("rst_addr", {2'd0, ram_addr}, 16'h0000);
    chk("rst_dout", {8'd0, isa_dout}, 16'h0000);
    chk("rst_char", {8'd0, char_byte}, 16'h0000);
    chk("rst_att", {8'd0, att_byte}, 16'h0000);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Display fetch of character/attribute pair
    disp_addr = 13'h0123; vram_read = 1'b1; vram_read_a0 = 1'b0; #1;
    chk("disp_addr_even", {2'd0, ram_addr}, 16'h0246);
    chk("disp_we", {15'd0, ram_we}, 16'h0000);
    tick();
    vram_read_a0 = 1'b1; vram_read_char = 1'b1; #1;
    chk("disp_addr_odd", {2'd0, ram_addr}, 16'h0247);
    tick();
    vram_read = 1'b0; vram_read_a0 = 1'b0; vram_read_char = 1'b0; vram_read_att = 1'b1; #1;
    chk("disp_char", {8'd0, char_byte}, 16'h0041);
    tick();
    vram_read_att = 1'b0; #1;
    chk("disp_att", {8'd0, att_byte}, 16'h001F);
    chk("disp_char_hold", {8'd0, char_byte}, 16'h0041);

    // ISA write inside an enabled window
    we0 = n_we; ack0 = n_ack;
    isa_op_enable = 1'b1; isa_req = 1'b1; isa_we = 1'b1; isa_addr = 14'h3FFF; isa_din = 8'hA5; #1;
    chk("wr_idle_we", {15'd0, ram_we}, 16'h0000);
    tick(); #1;
    chk("wr_acc1_we", {15'd0, ram_we}, 16'h0001);
    chk("wr_acc1_addr", {2'd0, ram_addr}, 16'h3FFF);
    chk("wr_acc1_data", {8'd0, ram_wdata}, 16'h00A5);
    chk("wr_acc1_ack", {15'd0, isa_ack}, 16'h0000);
    tick(); #1;
    chk("wr_acc2_we", {15'd0, ram_we}, 16'h0000);
    chk("wr_acc2_addr", {2'd0, ram_addr}, 16'h3FFF);
    tick(); #1;
    chk("wr_acc3_ack", {15'd0, isa_ack}, 16'h0001);
    isa_req = 1'b0; isa_op_enable = 1'b0;
    tick(); #1;
    chk("wr_hold_ack", {15'd0, isa_ack}, 16'h0000);
    tick();
    chk("wr_mem", {8'd0, mem[14'h3FFF]}, 16'h00A5);
    chk("wr_we_cycles", 16'(n_we - we0), 16'd1);
    chk("wr_acks", 16'(n_ack - ack0), 16'd1);
    chk("wr_dout_unchanged", {8'd0, isa_dout}, 16'h0000);

    // ISA read requested during a display fetch, waits for the window
    ack0 = n_ack;
    vram_read = 1'b1; disp_addr = 13'h0123; vram_read_a0 = 1'b0;
    isa_req = 1'b1; isa_we = 1'b0; isa_addr = 14'h1234; isa_op_enable = 1'b0;
    tick(); #1;
    chk("rd_wait_disp_addr", {2'd0, ram_addr}, 16'h0246);
    chk("rd_wait_we", {15'd0, ram_we}, 16'h0000);
    vram_read = 1'b0; #1;
    chk("rd_wait_no_access", {2'd0, ram_addr}, 16'h0000);
    isa_op_enable = 1'b1;
    tick();
    isa_op_enable = 1'b0; #1;
    chk("rd_acc1_addr", {2'd0, ram_addr}, 16'h1234);
    chk("rd_acc1_we", {15'd0, ram_we}, 16'h0000);
    tick(); tick(); #1;
    chk("rd_acc3_ack", {15'd0, isa_ack}, 16'h0001);
    tick(); #1;
    chk("rd_dout", {8'd0, isa_dout}, 16'h005C);
    chk("rd_hold_ack", {15'd0, isa_ack}, 16'h0000);
    isa_op_enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      chk("rd_hold_no_access", {2'd0, ram_addr}, 16'h0000);
    end
    isa_req = 1'b0; isa_op_enable = 1'b0;
    tick();
    chk("rd_single_ack", 16'(n_ack - ack0), 16'd1);

    // Write started on the last enabled cycle, followed directly by a display fetch
    ack0 = n_ack;
    isa_req = 1'b1; isa_we = 1'b1; isa_addr = 14'h0100; isa_din = 8'h3C; isa_op_enable = 1'b1;
    tick();
    isa_op_enable = 1'b0; #1;
    chk("ls_acc1_we", {15'd0, ram_we}, 16'h0001);
    chk("ls_acc1_addr", {2'd0, ram_addr}, 16'h0100);
    tick(); #1;
    chk("ls_acc2_addr", {2'd0, ram_addr}, 16'h0100);
    tick();
    disp_addr = 13'h0200; vram_read = 1'b1; vram_read_a0 = 1'b0; #1;
    chk("ls_acc3_ack", {15'd0, isa_ack}, 16'h0001);
    chk("ls_acc3_disp_addr", {2'd0, ram_addr}, 16'h0400);
    isa_req = 1'b0;
    tick();
    vram_read_a0 = 1'b1; vram_read_char = 1'b1;
    tick();
    vram_read = 1'b0; vram_read_a0 = 1'b0; vram_read_char = 1'b0; vram_read_att = 1'b1;
    tick();
    vram_read_att = 1'b0; #1;
    chk("ls_char", {8'd0, char_byte}, 16'h007A);
    chk("ls_att", {8'd0, att_byte}, 16'h0007);
    chk("ls_mem", {8'd0, mem[14'h0100]}, 16'h003C);
    chk("ls_acks", 16'(n_ack - ack0), 16'd1);

    // Reset in ACC2 of a write, then a fresh access on release
    ack0 = n_ack; we0 = n_we;
    isa_req = 1'b1; isa_we = 1'b1; isa_addr = 14'h0055; isa_din = 8'h99; isa_op_enable = 1'b1;
    tick(); tick();
    reset_n = 1'b0; isa_din = 8'h66; #1;
    chk("rstmid_we", {15'd0, ram_we}, 16'h0000);
    chk("rstmid_ack", {15'd0, isa_ack}, 16'h0000);
    chk("rstmid_dout", {8'd0, isa_dout}, 16'h0000);
    chk("rstmid_char", {8'd0, char_byte}, 16'h0000);
    chk("rstmid_att", {8'd0, att_byte}, 16'h0000);
    chk("rstmid_addr", {2'd0, ram_addr}, 16'h0000);
    chk("rstmid_wdata", {8'd0, ram_wdata}, 16'h0000);
    tick(); tick();
    chk("rstmid_no_ack", 16'(n_ack - ack0), 16'd0);
    chk("rstmid_one_write", 16'(n_we - we0), 16'd1);
    reset_n = 1'b1;
    tick(); #1;
    chk("rstrel_acc1_we", {15'd0, ram_we}, 16'h0001);
    chk("rstrel_acc1_addr", {2'd0, ram_addr}, 16'h0055);
    chk("rstrel_acc1_data", {8'd0, ram_wdata}, 16'h0066);
    tick(); tick(); #1;
    chk("rstrel_ack", {15'd0, isa_ack}, 16'h0001);
    isa_req = 1'b0; isa_op_enable = 1'b0;
    tick(); tick();
    chk("rstrel_mem", {8'd0, mem[14'h0055]}, 16'h0066);
    chk("rstrel_acks", 16'(n_ack - ack0), 16'd1);

    // 80-column write followed by two fetches of the same cell
`ifdef CGA_SNOW_EN
    snow_exp = 8'hB2;
`else
    snow_exp = 8'h41;
`endif
    hres_mode = 1'b1;
    isa_req = 1'b1; isa_we = 1'b1; isa_addr = 14'h0300; isa_din = 8'hB2; isa_op_enable = 1'b1;
    tick();
    isa_op_enable = 1'b0;
    tick(); tick();
    isa_req = 1'b0;
    tick(); tick();
    chk("snow_mem", {8'd0, mem[14'h0300]}, 16'h00B2);
    fetch(13'h0123);
    chk("snow_char_first", {8'd0, char_byte}, {8'd0, snow_exp});
    chk("snow_att_first", {8'd0, att_byte}, 16'h001F);
    fetch(13'h0123);
    chk("snow_char_second", {8'd0, char_byte}, 16'h0041);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cga_vram_arbiter.md
CGA_VRAM_ARBITER -- requirements
Module: cga_vram_arbiter

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  in  1  pixel/sequencer clock; all state on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 hres_mode  in  1  80-column mode flag; only used by the CGA_SNOW_EN logic.
REQ-005 vram_read, vram_read_a0, vram_read_char, vram_read_att, isa_op_enable  in  1 each  sequencer strobes.
REQ-006 disp_addr  in  13  CRTC display word address.
REQ-007 isa_req  in  1  CPU access request, level, held until isa_ack.
REQ-008 isa_we  in  1  1=write, 0=read; sampled with isa_req.
REQ-009 isa_addr  in  14  CPU byte address. isa_din  in  8  CPU write data.
REQ-010 isa_dout  out  8  CPU read data. isa_ack  out  1  one-cycle completion pulse.
REQ-011 ram_addr  out  14  VRAM byte address. ram_we  out  1  VRAM write enable. ram_wdata  out  8  VRAM write data.
REQ-012 ram_rdata  in  8  VRAM read data; synchronous RAM, valid one cycle after ram_addr.
REQ-013 char_byte, att_byte  out  8 each  latched display character and attribute.

Function
REQ-014 Address mux (combinational): vram_read=1 -> ram_addr={disp_addr, vram_read_a0}, ram_we=0; else ISA FSM in ACC1/ACC2 -> ram_addr=isa_addr (latched); else ram_addr=0.
REQ-015 Display always wins; ISA FSM never drives ram_we while vram_read=1.
REQ-016 char_byte <= ram_rdata on cycles with vram_read_char=1; att_byte <= ram_rdata on cycles with vram_read_att=1; otherwise hold.
REQ-017 ISA FSM states: IDLE, WAIT, ACC1, ACC2, ACC3, HOLD.
REQ-018 IDLE: isa_req=1 -> latch isa_we/isa_addr/isa_din; go ACC1 if isa_op_enable=1 same cycle, else WAIT.
REQ-019 WAIT: stay until isa_op_enable=1, then ACC1; a start occurs only in a cycle where isa_op_enable=1.
REQ-020 ACC1: ram_addr=latched addr, ram_we=latched we, ram_wdata=latched data; -> ACC2.
REQ-021 ACC2: ram_addr held, ram_we=0; -> ACC3.
REQ-022 ACC3: read -> isa_dout <= ram_rdata; isa_ack=1 for exactly this cycle; -> HOLD.
REQ-023 HOLD: stay while isa_req=1; isa_req=0 -> IDLE (one request = exactly one access).
REQ-024 Access latency from first enabled cycle to isa_ack: 3 cycles; total ISA occupancy of VRAM: 2 cycles (ACC1, ACC2).
REQ-025 isa_req dropped during WAIT/ACC*: access still completes and acks; then HOLD exits immediately.
REQ-026 isa_op_enable deasserting during ACC1..ACC3: access continues to completion.
REQ-027 isa_dout holds last read value; writes leave it unchanged.

Reset
REQ-028 reset_n=0 forces immediately: FSM=IDLE, isa_ack=0, ram_we=0, isa_dout=0, char_byte=0, att_byte=0, latched ISA regs=0.
REQ-029 Reset mid-access abandons the access: no ack, no further write; reset release with isa_req=1 starts a fresh access.

Configuration
REQ-030 Macro CGA_SNOW_EN defined: when hres_mode=1 and an ISA write executes ACC1, the next vram_read_char latch captures the latched ISA write data instead of ram_rdata (one snow character); the flag clears after that latch or on reset.
REQ-031 CGA_SNOW_EN undefined: no snow logic; char_byte always from ram_rdata; hres_mode unused.

Verification
REQ-032 Display fetch: disp_addr=0x0123, strobes at clkdiv 1..3, RAM[0x0246]=0x41, RAM[0x0247]=0x1F -> char_byte=0x41, att_byte=0x1F after clkdiv 3.
REQ-033 ISA write in window: isa_req=1, we=1, addr=0x3FFF, din=0xA5 while isa_op_enable=1 -> ram_we=1 for one cycle at 0x3FFF, isa_ack pulse 3 cycles after start, RAM[0x3FFF]=0xA5.
REQ-034 ISA read outside window: request during vram_read -> FSM in WAIT, no RAM access until isa_op_enable; isa_dout=RAM value, single ack; isa_req held 5 more cycles -> no second access.
REQ-035 Last-slot start: request begins on final isa_op_enable cycle -> ACC1/ACC2 finish before next vram_read; char/att fetch unaffected.
REQ-036 Reset during ACC2 of a write -> ram_we=0, no ack, all outputs 0; after release, held req completes normally.
REQ-037 CGA_SNOW_EN, hres_mode=1, ISA write din=0xB2 then fetch -> char_byte=0xB2 once, next fetch returns RAM data; without macro -> RAM data.
